// File: rtl/imem_loader.sv
// Boot-time loader: assembles a big-endian byte stream into 32-bit words, writes
// them to instruction memory and releases the core once the XOR checksum matches.
`timescale 1ns/1ps

module imem_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [7:0]  csum_q, csum_d;
    logic [23:0] asm_q, asm_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        core_rst_q, core_rst_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        xfer;
    logic [15:0] cnt_full;
    logic [15:0] word_inc;

    assign byte_ready = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
    assign xfer     = byte_valid & byte_ready;
    assign cnt_full = {count_q[15:8], byte_in};
    assign word_inc = word_cnt_q + 16'd1;

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples the pre-edge values computed by the combinational block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CNT_HI;
            count_q    <= '0;
            word_cnt_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
            asm_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= ADDR_BASE;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_cnt_q <= word_cnt_d;
            byte_idx_q <= byte_idx_d;
            csum_q     <= csum_d;
            asm_q      <= asm_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        csum_d     = csum_q;
        asm_d      = asm_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        error_d    = error_q;

        unique case (state_q)
            S_CNT_HI: if (xfer) begin
                count_d = {byte_in, 8'h00};
                state_d = S_CNT_LO;
            end
            S_CNT_LO: if (xfer) begin
                count_d = cnt_full;
                if ({1'b0, cnt_full} > MAX_N) begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end else if (cnt_full == 16'd0) begin
                    state_d = S_CSUM;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: if (xfer) begin
                csum_d     = csum_q ^ byte_in;
                byte_idx_d = byte_idx_q + 2'd1;
                if (byte_idx_q == 2'd3) begin
                    wdata_d = {asm_q, byte_in};
                    we_d    = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    asm_d = {asm_q[15:0], byte_in};
                end
            end
            // addr_q points at the word being written, so it advances only afterwards.
            S_WRITE: begin
                word_cnt_d = word_inc;
                addr_d     = addr_q + 32'd4;
                state_d    = (word_inc == count_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: if (xfer) begin
                if (byte_in == csum_q) begin
                    core_rst_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = S_RUN;
                end else begin
                    error_d = 1'b1;
                    state_d = S_ERR;
                end
            end
            S_RUN, S_ERR: ;
            default: state_d = S_ERR;
        endcase
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, zero-length, overflow, bad checksum,
// gapped stream and reset mid-load, checked against hand-computed values.
`timescale 1ns/1ps

module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        error;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    imem_loader #(.MAX_WORDS(256), .ADDR_BASE(32'h0000_0000)) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst  (core_rst),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Capture every write; the loader must not accept bytes in a write cycle.
    always @(negedge clk) begin
        if (!rst && imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
            check("ready_in_write", {31'd0, byte_ready}, 32'd0);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        check("rst_we",       {31'd0, imem_we},    32'd0);
        check("rst_addr",     imem_addr,           32'h0000_0000);
        check("rst_wdata",    imem_wdata,          32'h0000_0000);
        check("rst_core_rst", {31'd0, core_rst},   32'd1);
        check("rst_done",     {31'd0, done},       32'd0);
        check("rst_error",    {31'd0, error},      32'd0);
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        #1;
        check("rst_ready",    {31'd0, byte_ready}, 32'd1);
    endtask

    // Presents one byte after `gap` idle cycles; returns once it has transferred.
    task automatic send_byte(input logic [7:0] b, input int gap, output int xfer_cyc);
        int t;
        repeat (gap) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_in    = 8'hxx;
        end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        t = 0;
        while (!byte_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!byte_ready) begin
            check("ready_timeout", {31'd0, byte_ready}, 32'd1);
            byte_valid = 1'b0;
        end
        @(posedge clk);
        xfer_cyc = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_image(input int max_gap, output int first_cyc, output int last_cyc);
        logic [7:0] img [11];
        int c;
        img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
        first_cyc = 0;
        last_cyc  = 0;
        for (int i = 0; i < 11; i++) begin
            send_byte(img[i], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)), c);
            if (i == 0) first_cyc = c;
            last_cyc = c;
        end
        idle();
    endtask

    task automatic check_image(input string pfx);
        check({pfx, "_nwrites"}, wr_addr.size(), 32'd2);
        if (wr_addr.size() >= 2) begin
            check({pfx, "_addr0"}, wr_addr[0], 32'h0000_0000);
            check({pfx, "_data0"}, wr_data[0], 32'h2008_0005);
            check({pfx, "_addr1"}, wr_addr[1], 32'h0000_0004);
            check({pfx, "_data1"}, wr_data[1], 32'h0109_5020);
        end
        check({pfx, "_done"},     {31'd0, done},     32'd1);
        check({pfx, "_core_rst"}, {31'd0, core_rst}, 32'd0);
        check({pfx, "_error"},    {31'd0, error},    32'd0);
    endtask

    initial begin
        int c0, c1, dummy;

        // Continuous two-word load: 11 bytes plus two write stalls span 12 edges.
        do_reset();
        send_image(0, c0, c1);
        check_image("cont");
        check("cont_span", c1 - c0, 32'd12);
        repeat (3) @(negedge clk);
        check("cont_run_ready", {31'd0, byte_ready}, 32'd0);
        check("cont_done_held", {31'd0, done},       32'd1);

        // Zero-length image with matching checksum.
        do_reset();
        send_byte(8'h00, 0, dummy);
        send_byte(8'h00, 0, dummy);
        send_byte(8'h00, 0, dummy);
        idle();
        check("zero_done",     {31'd0, done},     32'd1);
        check("zero_core_rst", {31'd0, core_rst}, 32'd0);
        check("zero_nwrites",  wr_addr.size(),    32'd0);

        // Zero-length image with wrong checksum.
        do_reset();
        send_byte(8'h00, 0, dummy);
        send_byte(8'h00, 0, dummy);
        send_byte(8'hFF, 0, dummy);
        idle();
        check("zbad_error",    {31'd0, error},      32'd1);
        check("zbad_done",     {31'd0, done},       32'd0);
        check("zbad_core_rst", {31'd0, core_rst},   32'd1);
        check("zbad_ready",    {31'd0, byte_ready}, 32'd0);
        check("zbad_nwrites",  wr_addr.size(),      32'd0);

        // Count 257 exceeds MAX_WORDS.
        do_reset();
        send_byte(8'h01, 0, dummy);
        send_byte(8'h01, 0, dummy);
        idle();
        check("ovf_error", {31'd0, error},      32'd1);
        check("ovf_ready", {31'd0, byte_ready}, 32'd0);
        check("ovf_done",  {31'd0, done},       32'd0);
        repeat (5) @(negedge clk);
        check("ovf_done_late",  {31'd0, done},       32'd0);
        check("ovf_ready_late", {31'd0, byte_ready}, 32'd0);

        // One word, checksum 0x00 instead of 0x01.
        do_reset();
        send_byte(8'h00, 0, dummy);
        send_byte(8'h01, 0, dummy);
        send_byte(8'h00, 0, dummy);
        send_byte(8'h00, 0, dummy);
        send_byte(8'h00, 0, dummy);
        send_byte(8'h01, 0, dummy);
        send_byte(8'h00, 0, dummy);
        idle();
        check("bad_nwrites", wr_addr.size(), 32'd1);
        if (wr_addr.size() >= 1) begin
            check("bad_addr0", wr_addr[0], 32'h0000_0000);
            check("bad_data0", wr_data[0], 32'h0000_0001);
        end
        check("bad_error",    {31'd0, error},    32'd1);
        check("bad_core_rst", {31'd0, core_rst}, 32'd1);
        check("bad_done",     {31'd0, done},     32'd0);

        // Same two-word image with random valid gaps.
        do_reset();
        send_image(7, c0, c1);
        check_image("gap");

        // Reset after three payload bytes, then a full load.
        do_reset();
        send_byte(8'h00, 0, dummy);
        send_byte(8'h02, 0, dummy);
        send_byte(8'h20, 0, dummy);
        send_byte(8'h08, 0, dummy);
        send_byte(8'h00, 0, dummy);
        idle();
        do_reset();
        send_image(0, c0, c1);
        check_image("mid");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
